// File: rtl/icache_pkg.sv
// Shared widths, types and state encoding for the instruction cache.
package icache_pkg;

  localparam int unsigned ICACHE_INDEX_BITS  = 6;
  localparam int unsigned ICACHE_OFFSET_BITS = 4;
  localparam int unsigned ICACHE_TAG_BITS    = 32 - ICACHE_INDEX_BITS - ICACHE_OFFSET_BITS;

  typedef logic [31:0]  addr_t;
  typedef logic [127:0] line_t;
  typedef logic [31:0]  inst_t;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_FILL = 1'b1
  } icache_state_e;

  // Little-endian word select: word w lives at line[32w+31:32w].
  function automatic inst_t icache_word_sel(input line_t line, input logic [1:0] w);
    return line[{w, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Line storage for the direct-mapped icache: data, tag and valid arrays.
// Asynchronous read, one synchronous write port, valid bits cleared on rst.
module icache_line_ram
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int unsigned TAG_BITS   = ICACHE_TAG_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  output line_t                 o_rd_line,
  output logic [TAG_BITS-1:0]   o_rd_tag,
  output logic                  o_rd_valid,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  line_t                 i_wr_line
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  line_t                 r_data [LINES];
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [LINES-1:0]      r_valid;

  assign o_rd_line  = r_data[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_valid = r_valid[i_rd_index];

  // Valid bits: cleared by reset, set by a line fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Data and tag payload: written on fill, no reset needed behind valid.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_data[i_wr_index] <= i_wr_line;
      r_tag[i_wr_index]  <= i_wr_tag;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache. Hits answer in one cycle;
// misses fetch a 16-byte line from the memory controller, with the
// requesting word forwarded on the fill edge if the fetcher still wants it.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic [31:0]  addr_from_fetcher,
  input  logic         valid_from_fetcher,
  output logic [31:0]  inst_to_fetcher,
  output logic         ready_to_fetcher,
  output logic [31:0]  addr_to_mem,
  output logic         valid_to_mem,
  input  logic [127:0] data_from_mem,
  input  logic         ready_from_mem
);

  localparam int unsigned OFFSET_BITS = ICACHE_OFFSET_BITS;
  localparam int unsigned TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;

  icache_state_e         r_state, w_state_next;
  inst_t                 r_inst, w_inst_next;
  logic                  r_ready, w_ready_next;
  addr_t                 r_addr_mem, w_addr_mem_next;
  logic                  r_valid_mem, w_valid_mem_next;
  logic [INDEX_BITS-1:0] r_fill_index, w_fill_index_next;
  logic [TAG_BITS-1:0]   r_fill_tag, w_fill_tag_next;

  logic [TAG_BITS-1:0]   w_req_tag;
  logic [INDEX_BITS-1:0] w_req_index;
  logic [1:0]            w_req_word;
  line_t                 w_rd_line;
  logic [TAG_BITS-1:0]   w_rd_tag;
  logic                  w_rd_valid;
  logic                  w_hit;
  logic                  w_fill_match;
  logic                  w_we;
  logic                  w_unused;

  assign w_req_tag    = addr_from_fetcher[31 -: TAG_BITS];
  assign w_req_index  = addr_from_fetcher[OFFSET_BITS +: INDEX_BITS];
  assign w_req_word   = addr_from_fetcher[3:2];
  assign w_unused     = ^addr_from_fetcher[1:0];
  assign w_hit        = w_rd_valid && (w_rd_tag == w_req_tag);
  assign w_fill_match = (w_req_tag == r_fill_tag) && (w_req_index == r_fill_index);

  icache_line_ram #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_line_ram (
    .clk        (clk),
    .rst        (rst),
    .i_rd_index (w_req_index),
    .o_rd_line  (w_rd_line),
    .o_rd_tag   (w_rd_tag),
    .o_rd_valid (w_rd_valid),
    .i_we       (w_we),
    .i_wr_index (r_fill_index),
    .i_wr_tag   (r_fill_tag),
    .i_wr_line  (data_from_mem)
  );

  // State register; rdy low freezes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ICACHE_IDLE;
    end else if (rdy) begin
      r_state <= w_state_next;
    end
  end

  // Next state, registered-output next values and the fill write strobe.
  always_comb begin
    w_state_next      = r_state;
    w_inst_next       = r_inst;
    w_ready_next      = 1'b0;
    w_addr_mem_next   = r_addr_mem;
    w_valid_mem_next  = r_valid_mem;
    w_fill_index_next = r_fill_index;
    w_fill_tag_next   = r_fill_tag;
    w_we              = 1'b0;
    unique case (r_state)
      ICACHE_IDLE: begin
        if (valid_from_fetcher && !r_ready) begin
          if (w_hit) begin
            w_inst_next  = icache_word_sel(w_rd_line, w_req_word);
            w_ready_next = 1'b1;
          end else begin
            w_fill_index_next = w_req_index;
            w_fill_tag_next   = w_req_tag;
            w_addr_mem_next   = {w_req_tag, w_req_index, {OFFSET_BITS{1'b0}}};
            w_valid_mem_next  = 1'b1;
            w_state_next      = ICACHE_FILL;
          end
        end
      end
      ICACHE_FILL: begin
        if (ready_from_mem) begin
          w_we             = rdy;
          w_valid_mem_next = 1'b0;
          w_state_next     = ICACHE_IDLE;
          // Forward straight from the incoming line when the fetcher is still
          // asking for this line; the word index comes from its current address.
          if (valid_from_fetcher && w_fill_match) begin
            w_ready_next = 1'b1;
            w_inst_next  = icache_word_sel(data_from_mem, w_req_word);
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and latched fill target.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst       <= '0;
      r_ready      <= 1'b0;
      r_addr_mem   <= '0;
      r_valid_mem  <= 1'b0;
      r_fill_index <= '0;
      r_fill_tag   <= '0;
    end else if (rdy) begin
      r_inst       <= w_inst_next;
      r_ready      <= w_ready_next;
      r_addr_mem   <= w_addr_mem_next;
      r_valid_mem  <= w_valid_mem_next;
      r_fill_index <= w_fill_index_next;
      r_fill_tag   <= w_fill_tag_next;
    end
  end

  assign inst_to_fetcher  = r_inst;
  assign ready_to_fetcher = r_ready;
  assign addr_to_mem      = r_addr_mem;
  assign valid_to_mem     = r_valid_mem;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios followed by random
// fetches, all checked against a tag/valid reference model of the cache.
module tb_icache;

  logic         clk;
  logic         rst;
  logic         rdy;
  logic [31:0]  addr_from_fetcher;
  logic         valid_from_fetcher;
  logic [31:0]  inst_to_fetcher;
  logic         ready_to_fetcher;
  logic [31:0]  addr_to_mem;
  logic         valid_to_mem;
  logic [127:0] data_from_mem;
  logic         ready_from_mem;

  int checks = 0;
  int errors = 0;

  // Reference model: which line address each index currently holds.
  bit [63:0]   m_valid;
  logic [27:0] m_line [64];

  icache #(.INDEX_BITS(6)) dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .addr_from_fetcher  (addr_from_fetcher),
    .valid_from_fetcher (valid_from_fetcher),
    .inst_to_fetcher    (inst_to_fetcher),
    .ready_to_fetcher   (ready_to_fetcher),
    .addr_to_mem        (addr_to_mem),
    .valid_to_mem       (valid_to_mem),
    .data_from_mem      (data_from_mem),
    .ready_from_mem     (ready_from_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Backing memory contents, a fixed function of the line address.
  function automatic logic [127:0] mem_line(input logic [31:0] la);
    logic [127:0] l;
    if (la == 32'h0000_1000) return 128'h33333333_22222222_11111111_00000000;
    l = '0;
    for (int k = 0; k < 4; k++)
      l = l | (128'((la * 32'h9E3779B1) + (32'(k) * 32'h0101_0101) ^ 32'h5A5A_0000) << (32 * k));
    return l;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] line, input logic [31:0] a);
    logic [127:0] s;
    s = line >> (32 * a[3:2]);
    return s[31:0];
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[9:4]] && (m_line[a[9:4]] == a[31:4]);
  endfunction

  // One fetch of address a. mode: 0 plain, 1 drop valid during fill,
  // 2 change address to a2 during fill. stall: rdy low 5 cycles in fill.
  task automatic fetch(input logic [31:0] a, input int unsigned lat,
                       input int unsigned mode, input logic [31:0] a2, input bit stall);
    logic [31:0] la;
    logic [31:0] held_inst;
    bit byp;
    la = {a[31:4], 4'h0};
    valid_from_fetcher = 1'b1;
    addr_from_fetcher  = a;
    if (model_hit(a)) begin
      @(negedge clk);
      chk("hit_ready", ready_to_fetcher, 1'b1);
      chk("hit_inst", inst_to_fetcher, word_of(mem_line(la), a));
      chk("hit_no_req", valid_to_mem, 1'b0);
      valid_from_fetcher = 1'b0;
      @(negedge clk);
      chk("hit_pulse_end", ready_to_fetcher, 1'b0);
    end else begin
      @(negedge clk);
      chk("miss_req", valid_to_mem, 1'b1);
      chk("miss_addr", addr_to_mem, la);
      chk("miss_no_ready", ready_to_fetcher, 1'b0);
      held_inst = inst_to_fetcher;
      for (int i = 0; i < int'(lat); i++) begin
        if (mode == 1 && i == 0) valid_from_fetcher = 1'b0;
        if (mode == 2 && i == 0) addr_from_fetcher = a2;
        if (stall && i == 1) begin
          rdy = 1'b0;
          repeat (5) begin
            @(negedge clk);
            chk("stall_req", valid_to_mem, 1'b1);
            chk("stall_addr", addr_to_mem, la);
            chk("stall_ready", ready_to_fetcher, 1'b0);
            chk("stall_inst", inst_to_fetcher, held_inst);
          end
          rdy = 1'b1;
        end
        @(negedge clk);
        chk("fill_req_held", valid_to_mem, 1'b1);
        chk("fill_addr_held", addr_to_mem, la);
        chk("fill_no_ready", ready_to_fetcher, 1'b0);
      end
      ready_from_mem = 1'b1;
      data_from_mem  = mem_line(la);
      byp = valid_from_fetcher && (addr_from_fetcher[31:4] == a[31:4]);
      @(negedge clk);
      ready_from_mem = 1'b0;
      data_from_mem  = {$urandom, $urandom, $urandom, $urandom};
      m_valid[a[9:4]] = 1'b1;
      m_line[a[9:4]]  = a[31:4];
      chk("fill_req_drop", valid_to_mem, 1'b0);
      chk("fill_bypass_ready", ready_to_fetcher, byp);
      if (byp) chk("fill_bypass_inst", inst_to_fetcher, word_of(mem_line(la), addr_from_fetcher));
      valid_from_fetcher = 1'b0;
      @(negedge clk);
      chk("post_fill_no_req", valid_to_mem, 1'b0);
      chk("post_fill_ready_clr", ready_to_fetcher, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] a2;
    int unsigned mode;
    rst = 1'b1;
    rdy = 1'b1;
    addr_from_fetcher  = '0;
    valid_from_fetcher = 1'b0;
    data_from_mem      = '0;
    ready_from_mem     = 1'b0;
    m_valid = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready_to_fetcher, 1'b0);
    chk("rst_valid_mem", valid_to_mem, 1'b0);
    chk("rst_addr_mem", addr_to_mem, 32'h0);
    chk("rst_inst", inst_to_fetcher, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, then hit on the same line.
    fetch(32'h0000_1004, 20, 0, 32'h0, 1'b0);
    chk("cold_inst_known", word_of(mem_line(32'h1000), 32'h1004), 32'h1111_1111);
    fetch(32'h0000_100C, 1, 0, 32'h0, 1'b0);
    // Conflict on index 0.
    fetch(32'h0000_1400, 4, 0, 32'h0, 1'b0);
    fetch(32'h0000_1000, 3, 0, 32'h0, 1'b0);
    // Aborted fill is still written; later fetch hits.
    fetch(32'h0000_2000, 5, 1, 32'h0, 1'b0);
    fetch(32'h0000_2008, 1, 0, 32'h0, 1'b0);
    // rdy stall during fill.
    fetch(32'h0000_3004, 6, 0, 32'h0, 1'b1);
    // ready_from_mem outside FILL is ignored and corrupts nothing.
    ready_from_mem = 1'b1;
    data_from_mem  = {4{32'hDEAD_BEEF}};
    @(negedge clk);
    ready_from_mem = 1'b0;
    chk("idle_mem_ready_no_ready", ready_to_fetcher, 1'b0);
    chk("idle_mem_ready_no_req", valid_to_mem, 1'b0);
    fetch(32'h0000_3008, 1, 0, 32'h0, 1'b0);
    // Redirect within the fill line (bypass uses new word) and away from it.
    fetch(32'h0000_4000, 4, 2, 32'h0000_400C, 1'b0);
    fetch(32'h0000_5000, 3, 2, 32'h0000_6004, 1'b0);
    fetch(32'h0000_6004, 2, 0, 32'h0, 1'b0);

    // Reset three cycles into a fill.
    valid_from_fetcher = 1'b1;
    addr_from_fetcher  = 32'h0000_7010;
    @(negedge clk);
    chk("rstfill_req", valid_to_mem, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    valid_from_fetcher = 1'b0;
    @(negedge clk);
    chk("rstfill_valid_mem", valid_to_mem, 1'b0);
    chk("rstfill_ready", ready_to_fetcher, 1'b0);
    chk("rstfill_addr", addr_to_mem, 32'h0);
    rst = 1'b0;
    m_valid = '0;
    @(negedge clk);
    chk("rstfill_model_miss", 128'(model_hit(32'h0000_1000)), 128'(0));
    fetch(32'h0000_1000, 2, 0, 32'h0, 1'b0);

    // Random fetches over a small address pool so hits and conflicts occur.
    for (int n = 0; n < 60; n++) begin
      a  = {20'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'($urandom), 2'($urandom)};
      a2 = {20'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'($urandom), 2'($urandom)};
      mode = $urandom_range(0, 2);
      fetch(a, $urandom_range(1, 6), mode, a2, ($urandom_range(0, 7) == 0));
      if (mode == 2) fetch(a2, $urandom_range(1, 4), 0, 32'h0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
